// File: rtl/demux_pipeline.sv
// Scatters a stream of 32-bit words into a 16-lane byte line and hands the full line off.
// Define DEMUX_PIPELINE_ADDR_EN for addressed slot writes through `control`.
module demux_pipeline (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] data_in,
`ifdef DEMUX_PIPELINE_ADDR_EN
  input  logic [1:0]  control,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  data_out_0,
  output logic [7:0]  data_out_1,
  output logic [7:0]  data_out_2,
  output logic [7:0]  data_out_3,
  output logic [7:0]  data_out_4,
  output logic [7:0]  data_out_5,
  output logic [7:0]  data_out_6,
  output logic [7:0]  data_out_7,
  output logic [7:0]  data_out_8,
  output logic [7:0]  data_out_9,
  output logic [7:0]  data_out_10,
  output logic [7:0]  data_out_11,
  output logic [7:0]  data_out_12,
  output logic [7:0]  data_out_13,
  output logic [7:0]  data_out_14,
  output logic [7:0]  data_out_15,
  output logic [1:0]  slot
);

  typedef enum logic {StFill, StFull} state_e;

  state_e      state_q, state_d;
  logic        accept;
  logic        line_done;
  logic [1:0]  wr_slot;
  logic [7:0]  lane_q [16];

  assign out_valid = (state_q == StFull);
  assign in_ready  = !clear && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;

`ifdef DEMUX_PIPELINE_ADDR_EN
  logic [3:0] mask_q, mask_d, wr_onehot;

  assign wr_slot   = control;
  assign wr_onehot = 4'b0001 << control;
  assign line_done = (state_q == StFill) && accept && ((mask_q | wr_onehot) == 4'hF);
  // 2-bit sum wraps, giving popcount mod 4
  assign slot = {1'b0, mask_q[0]} + {1'b0, mask_q[1]} + {1'b0, mask_q[2]} + {1'b0, mask_q[3]};

  always_comb begin
    mask_d = mask_q;
    if (clear) begin
      mask_d = '0;
    end else if (state_q == StFull) begin
      if (out_ready) mask_d = accept ? wr_onehot : 4'h0;
    end else if (accept) begin
      mask_d = mask_q | wr_onehot;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mask_q <= '0;
    else        mask_q <= mask_d;
  end
`else
  logic [1:0] cnt_q, cnt_d;

  assign wr_slot   = cnt_q;
  assign slot      = cnt_q;
  assign line_done = (state_q == StFill) && accept && (cnt_q == 2'd3);

  // Counter wraps to 0 on completion, so a drain needs no explicit reload
  always_comb begin
    cnt_d = cnt_q;
    if (clear)       cnt_d = '0;
    else if (accept) cnt_d = cnt_q + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFill:  if (line_done) state_d = StFull;
      StFull:  if (out_ready) state_d = StFill;
      default: state_d = StFill;
    endcase
    if (clear) state_d = StFill;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StFill;
    else        state_q <= state_d;
  end

  // data_in[31:24] lands in the lowest lane of the slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) lane_q[i] <= '0;
    end else if (accept) begin
      for (int k = 0; k < 4; k++) lane_q[{wr_slot, 2'(k)}] <= data_in[31-8*k -: 8];
    end
  end

  assign data_out_0  = lane_q[0];
  assign data_out_1  = lane_q[1];
  assign data_out_2  = lane_q[2];
  assign data_out_3  = lane_q[3];
  assign data_out_4  = lane_q[4];
  assign data_out_5  = lane_q[5];
  assign data_out_6  = lane_q[6];
  assign data_out_7  = lane_q[7];
  assign data_out_8  = lane_q[8];
  assign data_out_9  = lane_q[9];
  assign data_out_10 = lane_q[10];
  assign data_out_11 = lane_q[11];
  assign data_out_12 = lane_q[12];
  assign data_out_13 = lane_q[13];
  assign data_out_14 = lane_q[14];
  assign data_out_15 = lane_q[15];

endmodule

// File: tb/tb_demux_pipeline.sv
// Directed self-checking bench for demux_pipeline; covers the addressed build when
// DEMUX_PIPELINE_ADDR_EN is defined.
module tb_demux_pipeline;

  logic         clk = 1'b0;
  logic         rst_n, clear, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]  data_in;
  logic [1:0]   slot;
  logic [7:0]   dout [16];
  logic [127:0] line;
`ifdef DEMUX_PIPELINE_ADDR_EN
  logic [1:0]   control;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0]  q [$];
  int           idx, lines;
  logic         acc, drn;
  logic [127:0] exp_line;

  always #5 clk = ~clk;

  demux_pipeline dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data_in    (data_in),
`ifdef DEMUX_PIPELINE_ADDR_EN
    .control    (control),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .data_out_0 (dout[0]),
    .data_out_1 (dout[1]),
    .data_out_2 (dout[2]),
    .data_out_3 (dout[3]),
    .data_out_4 (dout[4]),
    .data_out_5 (dout[5]),
    .data_out_6 (dout[6]),
    .data_out_7 (dout[7]),
    .data_out_8 (dout[8]),
    .data_out_9 (dout[9]),
    .data_out_10(dout[10]),
    .data_out_11(dout[11]),
    .data_out_12(dout[12]),
    .data_out_13(dout[13]),
    .data_out_14(dout[14]),
    .data_out_15(dout[15]),
    .slot       (slot)
  );

  assign line = {dout[0], dout[1], dout[2], dout[3], dout[4], dout[5], dout[6], dout[7],
                 dout[8], dout[9], dout[10], dout[11], dout[12], dout[13], dout[14], dout[15]};

  function automatic logic [31:0] mkw(input logic [7:0] b);
    return {b, b + 8'd1, b + 8'd2, b + 8'd3};
  endfunction

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_s(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_l(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; data_in = '0;
`ifdef DEMUX_PIPELINE_ADDR_EN
    control = '0;
`endif
    #12 rst_n = 1'b1;
    tick();
    chk_b("rst_out_valid", out_valid, 1'b0);
    chk_s("rst_slot", slot, 2'd0);
    chk_b("rst_in_ready", in_ready, 1'b1);
    chk_l("rst_lanes", line, 128'h0);

    // Four back-to-back words, consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      data_in  = mkw(8'(4 * i));
      tick();
      if (i < 3) chk_b("t1_early_valid", out_valid, 1'b0);
    end
    in_valid = 1'b0;
    chk_b("t1_valid", out_valid, 1'b1);
    chk_l("t1_line", line, 128'h000102030405060708090A0B0C0D0E0F);
    tick();
    chk_b("t1_valid_one_cycle", out_valid, 1'b0);
    chk_s("t1_slot", slot, 2'd0);

    // Backpressure: line frozen, no input taken
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      data_in  = mkw(8'(8'h10 + 4 * i));
      tick();
    end
    chk_b("t2_valid", out_valid, 1'b1);
    data_in = 32'hAABBCCDD;
    for (int i = 0; i < 5; i++) begin
      chk_b("t2_stall_in_ready", in_ready, 1'b0);
      chk_l("t2_stall_line", line, 128'h101112131415161718191A1B1C1D1E1F);
      tick();
    end
    out_ready = 1'b1;
    #1 chk_b("t2_release_in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk_b("t2_drain_valid", out_valid, 1'b0);
    chk_s("t2_drain_slot", slot, 2'd1);
    chk_l("t2_drain_line", line, 128'hAABBCCDD1415161718191A1B1C1D1E1F);

    // Clear after two words
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk_s("t3_slot_after_clear0", slot, 2'd0);
    in_valid = 1'b1;
    data_in  = 32'h30313233;
    tick();
    data_in  = 32'h34353637;
    tick();
    chk_s("t3_slot_two", slot, 2'd2);
    clear   = 1'b1;
    data_in = 32'hDEADBEEF;
    #1 chk_b("t3_clear_in_ready", in_ready, 1'b0);
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    chk_s("t3_slot_cleared", slot, 2'd0);
    chk_b("t3_valid_cleared", out_valid, 1'b0);
    chk_l("t3_lanes_kept", line, 128'h303132333435363718191A1B1C1D1E1F);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      data_in  = mkw(8'(8'h40 + 4 * i));
      tick();
      chk_b("t3_valid_progress", out_valid, i == 3);
    end
    in_valid = 1'b0;
    chk_l("t3_line", line, 128'h404142434445464748494A4B4C4D4E4F);
    tick();

    // Asynchronous reset mid-line
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      data_in  = mkw(8'(8'h50 + 4 * i));
      tick();
    end
    in_valid = 1'b0;
    chk_s("t4_slot_three", slot, 2'd3);
    #3 rst_n = 1'b0;
    #1;
    chk_l("t4_async_lanes", line, 128'h0);
    chk_b("t4_async_valid", out_valid, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    chk_s("t4_slot_after", slot, 2'd0);
    chk_b("t4_in_ready_after", in_ready, 1'b1);

`ifdef DEMUX_PIPELINE_ADDR_EN
    begin
      logic [1:0]  ctl   [5] = '{2'd3, 2'd1, 2'd1, 2'd0, 2'd2};
      logic [31:0] wd    [5] = '{32'h3C3D3E3F, 32'h11111111, 32'h14151617,
                                 32'h00010203, 32'h28292A2B};
      logic [1:0]  exp_s [5] = '{2'd1, 2'd2, 2'd2, 2'd3, 2'd0};
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
        in_valid = 1'b1;
        control  = ctl[i];
        data_in  = wd[i];
        tick();
        chk_s("t5_slot", slot, exp_s[i]);
        chk_b("t5_valid", out_valid, i == 4);
      end
      in_valid = 1'b0;
      chk_l("t5_line", line, 128'h00010203141516172829_2A2B3C3D3E3F);
      out_ready = 1'b1;
      tick();
      chk_b("t5_drain_valid", out_valid, 1'b0);
      chk_s("t5_drain_slot", slot, 2'd0);
    end
`endif

    // Stream of 12 words with random consumer stalls
    idx = 0;
    lines = 0;
    for (int cyc = 0; cyc < 300 && lines < 3; cyc++) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (idx < 12);
      data_in   = $urandom;
`ifdef DEMUX_PIPELINE_ADDR_EN
      control   = slot;
`endif
      #1;
      acc = in_valid && in_ready;
      drn = out_valid && out_ready;
      if (drn) begin
        exp_line = {q[0], q[1], q[2], q[3]};
        repeat (4) void'(q.pop_front());
        chk_l("t6_stream_line", line, exp_line);
        lines++;
      end
      if (acc) begin
        q.push_back(data_in);
        idx++;
      end
      tick();
    end
    in_valid = 1'b0;
    chk_i("t6_lines", lines, 3);
    chk_i("t6_words_sent", idx, 12);
    chk_i("t6_words_left", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
